// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between the decode stage, the ALU issue stage and the ALU/EX stage.
// The master drives instructions in and accepts results; the slave is the issue stage.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic             illegal_op;
  logic [CNT_W-1:0] issue_count;

  modport master (
    output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, illegal_op, issue_count
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, illegal_op, issue_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Single-entry issue register in front of the ALU: decodes opcode/funct into alu_control,
// selects operand b, and holds the entry until the ALU/EX stage takes it.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  alu_issue_stage_if.slave bus
);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_LT  = 3'b100;
  localparam logic [2:0] ALU_GE  = 3'b101;
  localparam logic [2:0] ALU_EQ  = 3'b110;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             ill;
  } issue_entry_t;

  issue_entry_t     ent_q, ent_d, dec_ent;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dec_ctrl;
  logic             dec_use_imm, dec_ill;
  logic             accept, xfer;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid_q && bus.out_ready;

  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_use_imm = 1'b0;
    dec_ill     = 1'b0;
    case (bus.opcode)
      OP_R, OP_I: begin
        dec_use_imm = (bus.opcode == OP_I);
        case (bus.funct3)
          3'b111:  dec_ctrl = ALU_AND;
          3'b110:  dec_ctrl = ALU_OR;
          // funct7_5 only selects sub for register-register ops; addi has no sub form
          3'b000:  dec_ctrl = (bus.opcode == OP_R && bus.funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  dec_ctrl = ALU_LT;
          default: dec_ill  = 1'b1;
        endcase
      end
      OP_LD, OP_ST: dec_use_imm = 1'b1;
      OP_BR: begin
        case (bus.funct3)
          3'b000:  dec_ctrl = ALU_EQ;
          3'b100:  dec_ctrl = ALU_LT;
          3'b101:  dec_ctrl = ALU_GE;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Unsupported encodings still flow downstream as a harmless add on rs1/rs2
    if (dec_ill) begin
      dec_ctrl    = ALU_ADD;
      dec_use_imm = 1'b0;
    end
  end

  always_comb begin
    dec_ent.a    = bus.rs1_data;
    dec_ent.b    = dec_use_imm ? bus.imm : bus.rs2_data;
    dec_ent.ctrl = dec_ctrl;
    dec_ent.ill  = dec_ill;
  end

  always_comb begin
    ent_d       = ent_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (xfer && !bus.flush) cnt_d = cnt_q + CNT_W'(1);
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      ent_d       = dec_ent;
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ent_q       <= ent_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.alu_a       = ent_q.a;
  assign bus.alu_b       = ent_q.b;
  assign bus.alu_control = ent_q.ctrl;
  assign bus.illegal_op  = ent_q.ill;
  assign bus.issue_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected entries queued on accept, compared while held.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  exp_t             sb_q[$];
  exp_t             pend;
  logic             ev = 1'b0;
  logic [CNT_W-1:0] ec = '0;

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      ev = 1'b0;
      ec = '0;
    end else begin
      logic x, a;
      chk("in_ready", bus.in_ready, !ev || bus.out_ready);
      chk("out_valid", bus.out_valid, ev);
      chk("issue_count", bus.issue_count, ec);
      if (ev && sb_q.size() > 0) begin
        chk("alu_a", bus.alu_a, sb_q[0].a);
        chk("alu_b", bus.alu_b, sb_q[0].b);
        chk("alu_control", bus.alu_control, sb_q[0].ctrl);
        chk("illegal_op", bus.illegal_op, sb_q[0].ill);
      end
      x = ev && bus.out_ready;
      a = bus.in_valid && (!ev || bus.out_ready);
      if (bus.flush) begin
        if (ev && sb_q.size() > 0) void'(sb_q.pop_front());
        ev = 1'b0;
      end else begin
        if (x) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
          ec = ec + 1'b1;
        end
        if (a) begin
          sb_q.push_back(pend);
          ev = 1'b1;
        end else if (x) begin
          ev = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                       input logic [WIDTH-1:0] im, input logic [2:0] e_ctrl,
                       input logic [WIDTH-1:0] e_b, input logic e_ill);
    bit done = 0;
    bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = f7;
    bus.rs1_data = r1; bus.rs2_data = r2; bus.imm = im;
    pend = '{a: r1, b: e_b, ctrl: e_ctrl, ill: e_ill};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, B = 7'b1100011;

  initial begin
    logic [CNT_W-1:0] c0;
    int n;
    bus.in_valid = 0; bus.opcode = 0; bus.funct3 = 0; bus.funct7_5 = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0; bus.flush = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_alu_control", bus.alu_control, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_count", bus.issue_count, 0);

    // Decode sweep, back-to-back
    issue(R, 3'b111, 0, 3, 2, 5, 3'b000, 2, 0);
    issue(R, 3'b110, 0, 3, 2, 5, 3'b001, 2, 0);
    issue(R, 3'b000, 0, 3, 2, 5, 3'b010, 2, 0);
    issue(R, 3'b000, 1, 3, 2, 5, 3'b011, 2, 0);
    issue(R, 3'b010, 0, 3, 2, 5, 3'b100, 2, 0);
    issue(I, 3'b000, 1, 3, 2, 5, 3'b010, 5, 0);
    issue(B, 3'b000, 0, 3, 2, 5, 3'b110, 2, 0);
    issue(B, 3'b100, 0, 3, 2, 5, 3'b100, 2, 0);
    issue(B, 3'b101, 0, 3, 2, 5, 3'b101, 2, 0);
    drain();
    chk("sweep_count", bus.issue_count, 9);

    // Async reset in the middle of a stall
    bus.out_ready = 1'b0;
    issue(R, 3'b111, 0, 9, 8, 0, 3'b000, 8, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_alu_control", bus.alu_control, 0);
    chk("arst_count", bus.issue_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;

    // Back-pressure: add held for 3 cycles while sub waits
    c0 = ec;
    bus.out_ready = 1'b0;
    fork
      begin
        issue(R, 3'b000, 0, 3, 2, 0, 3'b010, 2, 0);
        issue(R, 3'b000, 1, 7, 1, 0, 3'b011, 1, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", bus.issue_count, c0 + 2);

    // Flush beats a concurrent accept and transfer
    bus.out_ready = 1'b0;
    issue(R, 3'b110, 0, 3, 2, 0, 3'b001, 2, 0);
    c0 = ec;
    bus.opcode = R; bus.funct3 = 3'b111; bus.rs1_data = 4; bus.rs2_data = 6;
    pend = '{a: 4, b: 6, ctrl: 3'b000, ill: 0};
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_count", bus.issue_count, c0);

    // Illegal encoding still flows and is counted
    c0 = ec;
    issue(7'b1111111, 3'b000, 0, 11, 22, 33, 3'b010, 22, 1);
    chk("ill_flag", bus.illegal_op, 1);
    drain();
    chk("ill_count", bus.issue_count, c0 + 1);

    // Counter wrap
    n = 16'hFFFF - int'(ec);
    for (int i = 0; i < n; i++) issue(OP_LD_C(), 3'b010, 0, i, 0, 4, 3'b010, 4, 0);
    drain();
    chk("pre_wrap_count", bus.issue_count, 16'hFFFF);
    issue(7'b0100011, 3'b010, 0, 1, 0, 8, 3'b010, 8, 0);
    drain();
    chk("wrap_count", bus.issue_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  function automatic logic [6:0] OP_LD_C();
    return 7'b0000011;
  endfunction

  initial begin
    #2000000;
    chk("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU.
- Accepts decoded instruction fields plus register/immediate operands through a valid/ready handshake and translates opcode/funct into the ALU's 3-bit alu_control code.
- Registers the ALU operands a and b, and holds them stable until the downstream stage accepts.
- Also supports flush and counts issued operations.

Parameters:
- WIDTH, 32, operand width of a, b, rs1_data, rs2_data, imm.
- CNT_W, 16, width of issue_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- opcode  input  7  instruction opcode.
- funct3  input  3  instruction funct3.
- funct7_5  input  1  bit 30 of the instruction (sub select).
- rs1_data  input  WIDTH  source operand 1.
- rs2_data  input  WIDTH  source operand 2.
- imm  input  WIDTH  sign-extended immediate.
- flush  input  1  kill the held entry.
- out_valid  output  1  alu_a/alu_b/alu_control are valid.
- out_ready  input  1  downstream (ALU/EX) accepts.
- alu_a  output  WIDTH  ALU operand a.
- alu_b  output  WIDTH  ALU operand b.
- alu_control  output  3  ALU operation code.
- illegal_op  output  1  held entry had an unsupported encoding.
- issue_count  output  CNT_W  number of entries handed downstream.

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_a=0, alu_b=0, alu_control=3'b000, illegal_op=0, issue_count=0. Takes effect immediately and mid-transfer; the held entry is discarded.
- Single-entry register. in_ready = !out_valid || out_ready (combinational; full throughput, 1 op/cycle).
- Accept = in_valid && in_ready. On accept, next edge loads alu_a, alu_b, alu_control and illegal_op, and sets out_valid=1. Latency from accept to out_valid is 1 cycle.
- Transfer = out_valid && out_ready. If transfer occurs without accept, out_valid clears next edge. Simultaneous transfer and accept reloads the register and keeps out_valid=1.
- Stall (out_valid && !out_ready): all outputs hold exactly. in_ready=0.
- Decode, with alu_a = rs1_data always:
  - R-type 0110011, alu_b = rs2_data:
    - funct3 111 -> 000 (and)
    - funct3 110 -> 001 (or)
    - funct3 000, funct7_5=0 -> 010 (add)
    - funct3 000, funct7_5=1 -> 011 (sub)
    - funct3 010 -> 100 (less-than)
  - I-type 0010011, alu_b = imm, same funct3 mapping, funct7_5 ignored (always add for 000).
  - Load 0000011 / store 0100011: alu_b = imm, 010.
  - Branch 1100011, alu_b = rs2_data:
    - funct3 000 -> 110 (equal)
    - funct3 100 -> 100 (less-than)
    - funct3 101 -> 101 (greater-or-equal)
  - Any other opcode/funct3 combination: entry still accepted, alu_control=010, alu_b=rs2_data, illegal_op=1. Downstream is responsible for trapping.
- Flush: at the next edge out_valid=0 and no load occurs, even if in_valid && in_ready that cycle. Flush has priority over accept and transfer. in_ready is not gated by flush. Data registers may keep stale values; they are don't-care while out_valid=0.
- issue_count increments by 1 on each transfer, including illegal entries. It does not count on flush. It wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
- No combinational path from in_* to out_* data outputs. The only combinational path is out_ready -> in_ready.

Test Plan:
- Reset mid-stall: load an op, hold out_ready=0, assert rst asynchronously between edges -> out_valid=0, alu_control=000, issue_count=0 immediately, without waiting for an edge.
- Decode sweep, out_ready=1, rs1=3, rs2=2, imm=5:
  - R and/or/add/sub/slt -> alu_control 000/001/010/011/100 with alu_b=2.
  - I-add -> 010 with alu_b=5.
  - beq/blt/bge -> 110/100/101.
  - Each appears 1 cycle after accept; issue_count=9 at the end.
- Back-pressure: issue add(3,2) then sub(7,1) back-to-back with out_ready=0 for 3 cycles -> add entry held stable, in_ready=0, sub not lost. After out_ready=1: add transfers, then sub (011, a=7, b=1). issue_count +2.
- Flush priority: out_valid=1 holding or(3,2), assert flush together with a new in_valid and/and out_ready=1 -> next cycle out_valid=0, issue_count unchanged, and entry not loaded.
- Illegal encoding: opcode 1111111 -> accepted, illegal_op=1, alu_control=010, alu_b=rs2_data, counted on transfer.
- Counter wrap: preload by issuing 65535 transfers (or force) -> next transfer gives issue_count=0x0000.
